// File: rtl/xillybus_rd_sched.sv
// Round-robin read scheduler: shares the host-bound 128-bit Xillybus stream
// among NUM_SRC FWFT result sources and buffers words in a small FIFO that
// presents a standard (data-after-rden) FIFO face to xillybus_core.
module xillybus_rd_sched #(
  parameter int NUM_SRC    = 4,
  parameter int DW         = 128,
  parameter int BURST      = 16,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                  bus_clk,
  input  logic                  trn_reset_n,
  input  logic [NUM_SRC*DW-1:0] src_dout,
  input  logic [NUM_SRC-1:0]    src_empty_n,
  output logic [NUM_SRC-1:0]    src_read,
  input  logic [NUM_SRC-1:0]    src_enable,
  input  logic                  user_r_read_128_open,
  input  logic                  user_r_read_128_rden,
  output logic [DW-1:0]         user_r_read_128_data,
  output logic                  user_r_read_128_empty,
  output logic                  user_r_read_128_eof,
  output logic                  grant_valid,
  output logic [2:0]            grant_idx,
  output logic [31:0]           word_count
);

  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  logic [0:0]         state;
  logic [7:0]         burst_cnt;
  logic [DW-1:0]      mem [OBUF_DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;
  logic               is_open;
  logic [NUM_SRC-1:0] req;
  logic [2:0]         pick;
  logic               pick_hit;
  logic               g_vld, g_en;
  logic [DW-1:0]      g_dout;
  logic               push, pop, xfer_done;

  assign is_open = user_r_read_128_open;
  assign req     = src_enable & src_empty_n & {NUM_SRC{is_open}};

  // Next grant: requester with the smallest rotational distance past grant_idx.
  always_comb begin
    int d, best_d;
    d        = 0;
    best_d   = NUM_SRC;
    pick     = grant_idx;
    pick_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      d = (i + 2*NUM_SRC - int'(grant_idx) - 1) % NUM_SRC;
      if (req[i] && d < best_d) begin
        best_d   = d;
        pick     = 3'(i);
        pick_hit = 1'b1;
      end
    end
  end

  // Mux the granted source's handshake and data.
  always_comb begin
    g_vld  = 1'b0;
    g_en   = 1'b0;
    g_dout = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == 3'(i)) begin
        g_vld  = src_empty_n[i];
        g_en   = src_enable[i];
        g_dout = src_dout[i*DW +: DW];
      end
    end
  end

  // Push decision uses the pre-pop count, so a full buffer stalls even if
  // the host pops in the same cycle.
  assign push      = (state == S_XFER) & g_vld & g_en & is_open & (count < CW'(OBUF_DEPTH));
  assign pop       = user_r_read_128_rden & (count != '0);
  assign xfer_done = (push & (burst_cnt == 8'(BURST-1))) | ~g_vld | ~g_en | ~is_open;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_rd
    assign src_read[i] = push & (grant_idx == 3'(i));
  end

  assign user_r_read_128_empty = (count == '0);
  assign user_r_read_128_eof   = 1'b0;
  assign grant_valid           = (state == S_XFER);

  // Grant FSM: one IDLE cycle per grant boundary; grant_idx survives close.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state     <= S_IDLE;
      grant_idx <= 3'(NUM_SRC-1);
      burst_cnt <= '0;
    end else if (!is_open) begin
      state <= S_IDLE;
    end else if (state == S_IDLE) begin
      if (pick_hit) begin
        grant_idx <= pick;
        burst_cnt <= '0;
        state     <= S_XFER;
      end
    end else begin
      if (push)      burst_cnt <= burst_cnt + 8'd1;
      if (xfer_done) state     <= S_IDLE;
    end
  end

  // Buffer storage; contents need no reset since count gates visibility.
  always_ff @(posedge bus_clk) begin
    if (push) mem[wr_ptr] <= g_dout;
  end

  // Buffer pointers, registered output word and word counter; closing flushes.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      rd_ptr               <= '0;
      wr_ptr               <= '0;
      count                <= '0;
      user_r_read_128_data <= '0;
      word_count           <= '0;
    end else if (!is_open) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      word_count <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        word_count <= word_count + 32'd1;
      end
      if (pop) begin
        user_r_read_128_data <= mem[rd_ptr];
        rd_ptr               <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_xillybus_rd_sched.sv
// Bench for xillybus_rd_sched: queue-based sources, transaction-level
// reference scheduler/FIFO model, directed scenarios plus random soak.
module tb_xillybus_rd_sched;
  localparam int NUM_SRC = 4, DW = 128, BURST = 16, OBUF_DEPTH = 4;

  logic                  bus_clk = 1'b0;
  logic                  trn_reset_n = 1'b0;
  logic [NUM_SRC*DW-1:0] src_dout = '0;
  logic [NUM_SRC-1:0]    src_empty_n = '0, src_read, en = '0;
  logic                  open = 1'b0, rden = 1'b0;
  logic [DW-1:0]         data;
  logic                  empty, eof, gv;
  logic [2:0]            gidx;
  logic [31:0]           wc;

  xillybus_rd_sched #(.NUM_SRC(NUM_SRC), .DW(DW), .BURST(BURST), .OBUF_DEPTH(OBUF_DEPTH)) dut (
    .bus_clk(bus_clk), .trn_reset_n(trn_reset_n), .src_dout(src_dout),
    .src_empty_n(src_empty_n), .src_read(src_read), .src_enable(en),
    .user_r_read_128_open(open), .user_r_read_128_rden(rden),
    .user_r_read_128_data(data), .user_r_read_128_empty(empty),
    .user_r_read_128_eof(eof), .grant_valid(gv), .grant_idx(gidx), .word_count(wc));

  always #5 bus_clk = ~bus_clk;

  int n_chk = 0, n_err = 0;
  // reference model state
  logic [DW-1:0] srcq [NUM_SRC][$];
  logic [DW-1:0] obq[$];
  logic [DW-1:0] m_data;
  int            m_last, m_left;
  bit            m_busy, prev_gv;
  int unsigned   m_wc;
  int            seq_no = 0;
  int            rd_cnt [NUM_SRC];
  int            rd_seq[$], gq[$];
  logic [NUM_SRC-1:0] last_rd;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = NUM_SRC-1; m_busy = 0; m_left = 0; m_data = '0; m_wc = 0;
    obq.delete(); prev_gv = 0;
  endtask

  task automatic load(int s, int n);
    for (int k = 0; k < n; k++) begin
      seq_no++;
      srcq[s].push_back({32'(s), 32'(seq_no), 32'($urandom), 32'($urandom)});
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_empty_n[i] = (srcq[i].size() != 0);
      src_dout[i*DW +: DW] = (srcq[i].size() != 0) ? srcq[i][0] : '0;
    end
  endtask

  // One clock: predict this cycle's pops/pushes, check src_read, then
  // check the registered outputs after the edge.
  task automatic cycle();
    logic [NUM_SRC-1:0] exp_rd;
    int sz, g;
    bit push, ext, ok, found;
    exp_rd = '0; push = 0; ext = 0; g = 0; found = 0;
    drive_src();
    #1;
    sz = obq.size();
    if (!open) begin
      obq.delete(); m_wc = 0; m_busy = 0;
    end else begin
      if (m_busy) begin
        g    = m_last;
        ok   = (srcq[g].size() != 0) && en[g];
        push = ok && (sz < OBUF_DEPTH);
        ext  = !ok || (push && m_left == 1);
        if (push) exp_rd[g] = 1'b1;
      end else begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          int j;
          j = (m_last + k) % NUM_SRC;
          if (!found && en[j] && srcq[j].size() != 0) begin found = 1; g = j; end
        end
        if (found) begin m_last = g; m_busy = 1; m_left = BURST; end
      end
      if (rden && sz != 0) m_data = obq.pop_front();
      if (push) begin obq.push_back(srcq[g][0]); m_wc++; m_left--; end
      if (ext) m_busy = 0;
    end
    chk("src_read", 128'(src_read), 128'(exp_rd));
    last_rd = src_read;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_read[i]) begin
        rd_cnt[i]++;
        rd_seq.push_back(i);
        if (srcq[i].size() != 0) void'(srcq[i].pop_front());
      end
    @(negedge bus_clk);
    chk("empty", 128'(empty), 128'(obq.size() == 0));
    chk("data", data, m_data);
    chk("word_count", 128'(wc), 128'(m_wc));
    chk("grant_valid", 128'(gv), 128'(m_busy));
    chk("grant_idx", 128'(gidx), 128'(m_last));
    chk("eof", 128'(eof), 128'(0));
    if (gv && !prev_gv) gq.push_back(int'(gidx));
    prev_gv = gv;
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < NUM_SRC; i++) if (en[i] && srcq[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic drain(int max, string tag);
    int n = 0;
    rden = 1;
    while (n < max && (pending() || !empty || gv)) begin cycle(); n++; end
    chk(tag, 128'(n < max), 128'(1));
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NUM_SRC; i++) rd_cnt[i] = 0;
    rd_seq.delete(); gq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rs[$], rl[$];
    logic [DW-1:0] w0;
    model_reset(); clr_cnt(); drive_src();
    @(negedge bus_clk);
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_data", data, '0);
    chk("rst_wc", 128'(wc), 128'(0));
    chk("rst_gv", 128'(gv), 128'(0));
    chk("rst_gidx", 128'(gidx), 128'(NUM_SRC-1));
    chk("rst_rd", 128'(src_read), 128'(0));
    trn_reset_n = 1;

    // single source, 5 words, host always reading
    open = 1; en = '1; rden = 1; load(1, 5);
    repeat (12) cycle();
    chk("a_wc", 128'(wc), 128'(5));
    chk("a_gidx", 128'(gidx), 128'(1));
    chk("a_empty", 128'(empty), 128'(1));
    chk("a_rd1", 128'(rd_cnt[1]), 128'(5));
    open = 0; cycle();
    chk("a_wc_close", 128'(wc), 128'(0));
    open = 1;

    // all sources busy: 12 rotating grants of 16,16,8
    clr_cnt();
    for (int i = 0; i < NUM_SRC; i++) load(i, 40);
    drain(600, "b_drain");
    rs.delete(); rl.delete();
    foreach (rd_seq[k])
      if (rs.size() == 0 || rs[rs.size()-1] != rd_seq[k]) begin rs.push_back(rd_seq[k]); rl.push_back(1); end
      else rl[rl.size()-1]++;
    chk("b_nbursts", 128'(rs.size()), 128'(12));
    chk("b_ngrants", 128'(gq.size()), 128'(12));
    for (int k = 0; k < 12 && k < rs.size(); k++) begin
      chk("b_src", 128'(rs[k]), 128'((2 + k) % 4));
      chk("b_len", 128'(rl[k]), 128'(k < 8 ? 16 : 8));
    end
    chk("b_wc", 128'(wc), 128'(160));

    // host stalled: buffer fills, state holds in XFER
    clr_cnt(); rden = 0; load(0, 10); w0 = srcq[0][0];
    repeat (8) cycle();
    chk("c_reads", 128'(rd_cnt[0]), 128'(4));
    chk("c_gv", 128'(gv), 128'(1));
    rden = 1; cycle(); rden = 0;
    chk("c_data", data, w0);
    repeat (3) cycle();
    chk("c_reads2", 128'(rd_cnt[0]), 128'(5));
    drain(100, "c_drain");

    // enable mask 1010
    clr_cnt(); en = 4'b1010;
    for (int i = 0; i < NUM_SRC; i++) load(i, 20);
    n = 0;
    while ((srcq[1].size() != 0 || srcq[3].size() != 0 || gv) && n < 400) begin
      rden = 1'($urandom_range(1)); cycle(); n++;
    end
    chk("d_reach", 128'(n < 400), 128'(1));
    chk("d_rd0", 128'(rd_cnt[0]), 128'(0));
    chk("d_rd2", 128'(rd_cnt[2]), 128'(0));
    chk("d_ngrants", 128'(gq.size()), 128'(4));
    foreach (gq[k]) chk("d_grant", 128'(gq[k]), 128'((k % 2) ? 3 : 1));
    en = '1; drain(300, "d_drain");

    // close mid-burst
    clr_cnt(); rden = 0; load(2, 10); n = 0;
    while (rd_cnt[2] < 3 && n < 20) begin cycle(); n++; end
    chk("e_reach", 128'(n < 20), 128'(1));
    open = 0; cycle();
    chk("e_rd0", 128'(last_rd), 128'(0));
    chk("e_empty", 128'(empty), 128'(1));
    chk("e_wc", 128'(wc), 128'(0));
    chk("e_gv", 128'(gv), 128'(0));
    load(3, 5); open = 1; gq.delete(); n = 0;
    while (gq.size() == 0 && n < 10) begin cycle(); n++; end
    if (gq.size() != 0) chk("e_next", 128'(gq[0]), 128'(3));
    else chk("e_next_timeout", 128'(0), 128'(1));
    drain(300, "e_drain");

    // random soak
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_SRC; i++)
        if ($urandom_range(3) == 0 && srcq[i].size() < 30) load(i, $urandom_range(3, 1));
      rden = ($urandom_range(2) != 0);
      if ($urandom_range(49) == 0) en = 4'($urandom);
      open = ($urandom_range(149) != 0);
      cycle();
    end
    open = 1; en = '1; drain(3000, "f_drain");

    // asynchronous reset mid-transfer
    rden = 0;
    for (int i = 0; i < NUM_SRC; i++) load(i, 5);
    repeat (3) cycle();
    #2 trn_reset_n = 0;
    #1;
    chk("g_empty", 128'(empty), 128'(1));
    chk("g_data", data, '0);
    chk("g_wc", 128'(wc), 128'(0));
    chk("g_gv", 128'(gv), 128'(0));
    chk("g_gidx", 128'(gidx), 128'(NUM_SRC-1));
    chk("g_rd", 128'(src_read), 128'(0));
    @(negedge bus_clk);
    model_reset(); trn_reset_n = 1; gq.delete(); rden = 1; n = 0;
    while (gq.size() == 0 && n < 10) begin cycle(); n++; end
    if (gq.size() != 0) chk("g_first", 128'(gq[0]), 128'(0));
    else chk("g_first_timeout", 128'(0), 128'(1));
    drain(300, "g_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
